// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional even parity, stop bits.
// Optional parity stage is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        // A strobe coincident with the accept is consumed by ARM's wait, not the start bit
        if (tx_start) begin
          shift_d    = tx_data;
          busy_d     = 1'b1;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data;
`endif
          state_d    = StArm;
        end
      end

      StArm: begin
        if (baud) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = StData;
        end
      end

      StData: begin
        if (baud) begin
          if (bit_idx_q < LastIdx) begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
`endif

      StStop: begin
        if (baud) begin
          if (stop_cnt_q == LastStop) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames, reset mid-frame, busy rejection, 2 stop bits.
module tb_uart_tx;

  localparam int unsigned P = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int NBITS = 1 + 8 + PAR + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud;
  logic       tx_start = 1'b0;
  logic       tx_start2 = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx, tx_busy, tx_done;
  logic       tx2, tx_busy2, tx_done2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Free-running baud strobe, one clock in every P
  int unsigned bcnt = 0;
  always @(posedge clk) bcnt <= (bcnt == P - 1) ? 0 : bcnt + 1;
  assign baud = (bcnt == P - 1);

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud(baud), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud(baud), .tx_start(tx_start2), .tx_data(tx_data2),
    .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Send one frame on dut and check tx/busy/done on every clock until tx_done.
  task automatic run_frame(input logic [7:0] d, input logic par, input bit align,
                           input bit inject);
    logic [11:0] bits;
    int          pos;
    int          clks;
    bit          done_seen;
    bit          injected;
    logic        b;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    if (PAR == 1) bits[9] = par;

    if (align) begin
      for (int k = 0; k < 2 * P; k++) begin
        @(negedge clk);
        if (baud) break;
      end
    end else begin
      @(negedge clk);
    end
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    check_bit("accept_busy", tx_busy, 1'b1);
    check_bit("accept_tx", tx, 1'b1);
    check_bit("accept_done", tx_done, 1'b0);

    pos = -1;
    clks = 0;
    done_seen = 1'b0;
    injected = 1'b0;
    while (!done_seen && clks < (NBITS + 2) * P) begin
      @(negedge clk);
      b = baud;
      tx_data = ~d;
      if (inject && pos == 3 && !injected) begin
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        injected = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(posedge clk);
      #1;
      clks++;
      if (b) begin
        pos++;
        if (pos == 0 && align) check_int("start_latency", clks, P);
      end
      if (pos < NBITS) begin
        check_bit("tx_bit", tx, (pos < 0) ? 1'b1 : bits[pos]);
        check_bit("busy_in_frame", tx_busy, 1'b1);
        check_bit("done_in_frame", tx_done, 1'b0);
      end else begin
        check_bit("done_pulse", tx_done, 1'b1);
        check_bit("busy_at_done", tx_busy, 1'b0);
        check_bit("tx_at_done", tx, 1'b1);
        done_seen = 1'b1;
      end
    end
    tx_start = 1'b0;
    if (!done_seen) check_bit("frame_timeout", 1'b0, 1'b1);

    if (inject) begin
      repeat (3 * P) begin
        @(posedge clk);
        #1;
        check_bit("idle_tx_after_reject", tx, 1'b1);
        check_bit("idle_busy_after_reject", tx_busy, 1'b0);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         align;
    bit         inject;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : main
    int   e;
    int   clks;
    int   stop_clk;
    bit   done2;
    logic b;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h5B, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx", tx, 1'b1);
    check_bit("reset_busy", tx_busy, 1'b0);
    check_bit("reset_done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Consecutive non-aligned entries start on the clock after the previous tx_done
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].data, vecs[v].par, vecs[v].align, vecs[v].inject);
    end

    // Asynchronous reset during the start bit
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 0; k < 3 * P; k++) begin
      @(posedge clk);
      #1;
      if (tx == 1'b0) break;
    end
    check_bit("pre_reset_start_bit", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_reset_tx", tx, 1'b1);
    check_bit("async_reset_busy", tx_busy, 1'b0);
    check_bit("async_reset_done", tx_done, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_bit("reset_hold_done", tx_done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_bit("post_reset_tx", tx, 1'b1);
    check_bit("post_reset_done", tx_done, 1'b0);
    run_frame(8'hC3, 1'b0, 1'b0, 1'b0);

    // Two stop bits on dut2: line high for 2*P clocks before tx_done
    @(negedge clk);
    tx_start2 = 1'b1;
    tx_data2  = 8'hA5;
    @(posedge clk);
    #1;
    check_bit("dut2_accept_busy", tx_busy2, 1'b1);
    e = 0;
    clks = 0;
    stop_clk = -1;
    done2 = 1'b0;
    while (!done2 && clks < (NBITS + 4) * P) begin
      @(negedge clk);
      tx_start2 = 1'b0;
      b = baud;
      @(posedge clk);
      #1;
      clks++;
      if (b) e++;
      if (b && e == 10 + PAR) stop_clk = clks;
      if (tx_done2) begin
        done2 = 1'b1;
        check_int("dut2_done_edge", e, 12 + PAR);
        check_int("dut2_stop_len", clks - stop_clk, 2 * P);
        check_bit("dut2_busy_at_done", tx_busy2, 1'b0);
        check_bit("dut2_tx_at_done", tx2, 1'b1);
      end else if (e >= 10 + PAR) begin
        check_bit("dut2_stop_high", tx2, 1'b1);
      end
    end
    if (!done2) check_bit("dut2_timeout", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer that sits directly downstream of `BaudGenerator` and consumes its `baud` strobe. It accepts a parallel byte over a start/busy handshake and shifts it out LSB-first as a standard asynchronous frame on `tx`: a start bit, the data bits, an optional parity bit, then the stop bits. Each bit lasts exactly one baud period.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `baud`  in  1: one-`clk`-wide strobe, one per bit period, from `BaudGenerator`.
- `tx_start`  in  1: request to send `tx_data`; sampled only when `tx_busy` is 0.
- `tx_data`  in  DATA_WIDTH: byte to send; captured in the accept cycle.
- `tx`  out  1: serial line; idles high.
- `tx_busy`  out  1: high from the accept until the frame ends.
- `tx_done`  out  1: one-`clk` pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, shift register 0, bit/stop counters 0.
- Reset is asynchronous, including mid-frame: `tx` returns to 1 immediately and the frame is abandoned. No `tx_done` is issued for the abandoned frame.
- States and transitions. Outside IDLE, every transition happens only on a `clk` edge where `baud`=1.
  - IDLE: `tx`=1. If `tx_start`=1, latch `tx_data` into the shift register, set `tx_busy`=1 and go to ARM.
  - ARM: on `baud`, drive `tx`=0 and go to START.
  - START: on `baud`, drive `tx`=data[0], clear the bit index and go to DATA.
  - DATA: on `baud`, if index < DATA_WIDTH-1, increment the index and drive the next bit. Otherwise:
    - with parity enabled, drive the parity bit and go to PARITY;
    - without parity, drive `tx`=1 and go to STOP.
  - PARITY: on `baud`, drive `tx`=1 and go to STOP.
  - STOP: on `baud`, if the stop count is STOP_BITS-1, go to IDLE, clear `tx_busy` and pulse `tx_done`. Otherwise increment the stop count and keep `tx`=1.
- `tx_start` while `tx_busy`=1 is ignored. The data is not latched and no queueing occurs.
- `tx_data` may change freely after the accept cycle without affecting the frame.
- If `tx_start` and `baud` are both high in IDLE, the request is accepted. That strobe does not begin the start bit; the start bit begins on the next strobe.
- The bit index is sized to `$clog2(DATA_WIDTH)`. Increments never wrap past DATA_WIDTH-1.

## Timing
- Accept latency: `tx_busy` rises on the edge that samples `tx_start`.
- Start-bit latency: 1 to P clocks after the accept, where P is the baud period in clocks, depending on strobe phase.
- Frame length on `tx`: (1 + DATA_WIDTH + parity + STOP_BITS) × P clocks, measured from the start-bit edge.
- `tx_done` and the falling edge of `tx_busy` occur on the same clock edge.
- Back-to-back frames: a new `tx_start` is accepted on the clock after `tx_done` at the earliest. No `tx` glitch occurs between frames; the line stays 1.
- `tx` is a registered output. It never changes except on a `baud` edge or on reset.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. After the last data bit, `tx` carries even parity, the XOR of all data bits, for one baud period.
- Not defined: no PARITY state or parity logic exists. The last data bit is followed directly by stop bits, and the frame is one bit shorter.

## Test plan
- Reset: assert `rst` mid-frame asynchronously → `tx`=1 and `tx_busy`=0 immediately, with no `tx_done`. After release, the next `tx_start` sends a clean frame.
- Basic frame, no parity, P=4, `tx_data`=8'hA5 → `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. `tx_done` pulses once for 1 clock and `tx_busy` falls on the same edge.
- Parity build, `tx_data`=8'hA5 → parity bit 0. With `tx_data`=8'h01 → parity bit 1. Frame is 11 bits.
- Busy rejection: pulse `tx_start` with 8'h3C mid-frame of 8'hA5 → only 8'hA5 is transmitted, then the line idles at 1.
- Simultaneous events: `tx_start` coincident with `baud` in IDLE → start bit begins exactly P clocks later. `tx_start` on the clock after `tx_done` → accepted, and a second frame follows with the line staying 1 in between.
- STOP_BITS=2, P=4 → `tx` stays high 8 clocks after the last data bit before `tx_done`.
